zap_predecode_ldm_stm_seq: RTL and testbench

Block-transfer sequencer sitting directly upstream of the main decode stage. It accepts 36-bit instructions from the predecode/fetch path and passes ordinary instructions through with one register stage. It expands LDM/STM into a stream of single-register LDR/STR micro-ops plus base-copy and writeback micro-ops. While a sequence is in flight it stalls fetch, so decode only ever sees single-transfer memory operations.

---
 rtl/zap_predecode_ldm_stm_seq_pkg.sv | 56 +++++
 rtl/zap_predecode_reglist_pe.sv | 30 +++
 rtl/zap_predecode_ldm_stm_seq.sv | 165 ++++++++++++++++
 tb/tb_zap_predecode_ldm_stm_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/zap_predecode_ldm_stm_seq_pkg.sv
// Shared constants, types and micro-op builders for the LDM/STM sequencer.
package zap_predecode_ldm_stm_seq_pkg;

  localparam int              ARCH_REGS = 32;
  localparam int              REG_W     = $clog2(ARCH_REGS);
  // Scratch register that freezes the base address for the whole sequence.
  localparam logic [REG_W-1:0] TEMP_REG  = 5'd16;

  localparam logic [3:0] COND_NV = 4'hF;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0010;

  // Output register after reset: all zero except a never-executed condition.
  localparam logic [35:0] RESET_INSTR = {4'h0, COND_NV, 28'h0};

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  // Fields of the accepted block transfer, frozen for the whole sequence.
  typedef struct packed {
    logic [3:0] cond;
    logic       p;
    logic       u;
    logic       s;
    logic       l;
    logic [3:0] rn;
    logic       rn_hi;
  } blk_ctx_t;

  // MOV TEMP_REG, Rn
  function automatic logic [35:0] make_mov(input logic [3:0] cond, input logic [3:0] rn);
    return {3'b000, TEMP_REG[4],
            cond, 3'b000, OP_MOV, 1'b0, 4'h0, TEMP_REG[3:0], 8'h00, rn};
  endfunction

  // Single LDR/STR, pre-indexed off TEMP_REG, no writeback, word size.
  function automatic logic [35:0] make_xfer(input logic [3:0] cond, input logic up,
                                            input logic s, input logic l,
                                            input logic [3:0] rd, input logic [11:0] imm);
    return {1'b0, s, TEMP_REG[4], 1'b0,
            cond, 3'b010, 1'b1, up, 1'b0, 1'b0, l, TEMP_REG[3:0], rd, imm};
  endfunction

  // ADD/SUB Rn, TEMP_REG, #4N (imm8 form, rotate 0).
  function automatic logic [35:0] make_wb(input logic [3:0] cond, input logic up,
                                          input logic [3:0] rn, input logic rn_hi,
                                          input logic [4:0] n);
    return {2'b00, TEMP_REG[4], rn_hi,
            cond, 3'b001, (up ? OP_ADD : OP_SUB), 1'b0, TEMP_REG[3:0], rn,
            4'h0, {1'b0, n, 2'b00}};
  endfunction

endpackage

// File: rtl/zap_predecode_reglist_pe.sv
// Register-list priority encoder: lowest listed register (PC held back until
// it is the only one left), the list with that bit removed, and a popcount.
module zap_predecode_reglist_pe (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic [15:0] mask_next,
  output logic [4:0]  count
);

  // Pick the lowest non-PC register; fall back to PC when nothing else remains.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value unassigned and infers a latch.
    idx = 4'd15;
    for (int i = 14; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    mask_next      = mask;
    mask_next[idx] = 1'b0;
  end

  // Number of registers in the list.
  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + 5'(mask[i]);
    end
  end

endmodule

// File: rtl/zap_predecode_ldm_stm_seq.sv
// Block-transfer sequencer: passes ordinary instructions through one register
// stage and expands LDM/STM into MOV-base, single LDR/STR and writeback ops.
module zap_predecode_ldm_stm_seq
  import zap_predecode_ldm_stm_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_code_stall,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic [35:0] i_instruction,
  input  logic        i_instruction_valid,
  input  logic        i_irq,
  input  logic        i_fiq,
  output logic [35:0] o_instruction,
  output logic        o_instruction_valid,
  output logic        o_irq,
  output logic        o_fiq,
  output logic        o_stall_from_decode
);

  state_t      state, state_nxt;
  blk_ctx_t    ctx;
  logic [15:0] mask;
  logic [4:0]  cnt, k, n;
  logic        wb_pend;

  logic        is_blk, in_wb, hold, flush, advance;
  logic [15:0] pe_in, pe_next;
  logic [3:0]  pe_idx;
  logic [4:0]  pe_cnt;
  logic signed [7:0] off;
  logic [7:0]  mag;
  logic [35:0] uop;
  logic        take_xfer;

  assign is_blk = i_instruction_valid && (i_instruction[27:25] == 3'b100);
  // Loading the base register itself makes its writeback meaningless.
  assign in_wb  = i_instruction[21] &&
                  !(i_instruction[20] && i_instruction[i_instruction[19:16]]);
  // Popcount is only needed in IDLE, the encoder only in SEQ: share one unit.
  assign pe_in  = (state == SEQ) ? mask : i_instruction[15:0];

  zap_predecode_reglist_pe u_pe (
    .mask      (pe_in),
    .idx       (pe_idx),
    .mask_next (pe_next),
    .count     (pe_cnt)
  );

  // Resolve the stall/clear inputs by priority into hold, flush or advance.
  always_comb begin
    hold  = 1'b0;
    flush = 1'b0;
    if (i_code_stall)                                    hold  = 1'b1;
    else if (i_clear_from_writeback)                     flush = 1'b1;
    else if (i_data_stall)                               hold  = 1'b1;
    else if (i_clear_from_alu)                           flush = 1'b1;
    else if (i_stall_from_shifter || i_stall_from_issue) hold  = 1'b1;
  end
  assign advance = !hold && !flush;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: enter SEQ on a non-empty block transfer, leave on the last op.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else if (advance) begin
      case (state)
        IDLE: if (is_blk && (pe_cnt != 5'd0)) state_nxt = SEQ;
        SEQ:  if (cnt == 5'd1)                state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: next micro-op of the sequence and the fetch stall.
  always_comb begin
    // Offset from the frozen base; IB and DA start one word further up.
    off = $signed({1'b0, k, 2'b00});
    if (ctx.u == ctx.p) off = off + 8'sd4;
    if (!ctx.u)         off = off - $signed({1'b0, n, 2'b00});
    mag = off[7] ? 8'(-off) : 8'(off);

    uop       = make_xfer(ctx.cond, !off[7], ctx.s, ctx.l, pe_idx, {4'h0, mag});
    take_xfer = 1'b1;
    // Writeback goes after all ordinary registers but before a PC load.
    if ((mask[14:0] == 15'd0) && wb_pend) begin
      uop       = make_wb(ctx.cond, ctx.u, ctx.rn, ctx.rn_hi, n);
      take_xfer = 1'b0;
    end

    // Released in the cycle the last op loads so fetch moves on exactly once.
    if (state == SEQ) o_stall_from_decode = (cnt != 5'd1);
    else              o_stall_from_decode = is_blk && (pe_cnt != 5'd0);
  end

  // Output register and sequence context.
  always_ff @(posedge i_clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (i_reset) begin
      o_instruction       <= RESET_INSTR;
      o_instruction_valid <= 1'b0;
      o_irq               <= 1'b0;
      o_fiq               <= 1'b0;
      ctx                 <= '0;
      mask                <= '0;
      cnt                 <= '0;
      k                   <= '0;
      n                   <= '0;
      wb_pend             <= 1'b0;
    end else if (flush) begin
      o_instruction_valid <= 1'b0;
      o_irq               <= 1'b0;
      o_fiq               <= 1'b0;
      mask                <= '0;
      cnt                 <= '0;
      wb_pend             <= 1'b0;
    end else if (advance) begin
      if (state == IDLE) begin
        o_instruction_valid <= i_instruction_valid;
        o_irq               <= i_irq;
        o_fiq               <= i_fiq;
        o_instruction       <= i_instruction;
        if (is_blk && (pe_cnt == 5'd0)) begin
          o_instruction <= {i_instruction[35:32], COND_NV, i_instruction[27:0]};
        end else if (is_blk) begin
          o_instruction <= make_mov(i_instruction[31:28], i_instruction[19:16]);
          ctx <= '{cond:  i_instruction[31:28], p: i_instruction[24],
                   u:     i_instruction[23],    s: i_instruction[22],
                   l:     i_instruction[20],    rn: i_instruction[19:16],
                   rn_hi: i_instruction[33]};
          mask    <= i_instruction[15:0];
          n       <= pe_cnt;
          k       <= '0;
          wb_pend <= in_wb;
          cnt     <= pe_cnt + 5'(in_wb);
        end
      end else begin
        o_instruction_valid <= 1'b1;
        o_irq               <= 1'b0;
        o_fiq               <= 1'b0;
        o_instruction       <= uop;
        cnt                 <= cnt - 5'd1;
        if (take_xfer) begin
          mask <= pe_next;
          k    <= k + 5'd1;
        end else begin
          wb_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_zap_predecode_ldm_stm_seq.sv
// Scoreboard bench for the LDM/STM sequencer: directed instructions with
// hand-assembled expected micro-ops queued ahead of time, checked by a monitor.
module tb_zap_predecode_ldm_stm_seq;

  typedef struct {
    logic [35:0] instr;
    logic        irq;
    logic        fiq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_stall, clear_wb, data_stall, clear_alu, shifter_stall, issue_stall;
  logic [35:0] instr_in;
  logic        valid_in, irq_in, fiq_in;
  logic [35:0] instr_out;
  logic        valid_out, irq_out, fiq_out, stall_out;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  zap_predecode_ldm_stm_seq dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_code_stall           (code_stall),
    .i_clear_from_writeback (clear_wb),
    .i_data_stall           (data_stall),
    .i_clear_from_alu       (clear_alu),
    .i_stall_from_shifter   (shifter_stall),
    .i_stall_from_issue     (issue_stall),
    .i_instruction          (instr_in),
    .i_instruction_valid    (valid_in),
    .i_irq                  (irq_in),
    .i_fiq                  (fiq_in),
    .o_instruction          (instr_out),
    .o_instruction_valid    (valid_out),
    .o_irq                  (irq_out),
    .o_fiq                  (fiq_out),
    .o_stall_from_decode    (stall_out)
  );

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [35:0] instr, input logic irq, input logic fiq);
    exp_t x;
    x.instr = instr;
    x.irq   = irq;
    x.fiq   = fiq;
    exp_q.push_back(x);
  endtask

  // Monitor: downstream takes an op whenever it is valid and no hold is active.
  always @(negedge clk) begin
    if (!rst && valid_out && !(code_stall || data_stall || shifter_stall || issue_stall)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_uop: got %h required none", instr_out);
      end else begin
        e = exp_q.pop_front();
        check("uop", instr_out, e.instr);
        check("uop_irq", 36'(irq_out), 36'(e.irq));
        check("uop_fiq", 36'(fiq_out), 36'(e.fiq));
      end
    end
  end

  // Fetch model: present until the sequencer drops its stall, then move on.
  task automatic present(input string name, input logic [35:0] instr,
                         input logic irq, input logic fiq, input int exp_stall);
    int  stall_cycles = 0;
    bit  released     = 1'b0;
    instr_in = instr;
    valid_in = 1'b1;
    irq_in   = irq;
    fiq_in   = fiq;
    for (int c = 0; c < 64 && !released; c++) begin
      @(negedge clk);
      if (stall_out) stall_cycles++;
      else           released = 1'b1;
    end
    if (!released) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: stall still high after 64 cycles, required release", name);
    end
    check({name, "_stall_cycles"}, 36'(stall_cycles), 36'(exp_stall));
    @(posedge clk); #1;
    valid_in = 1'b0;
    irq_in   = 1'b0;
    fiq_in   = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (6) @(posedge clk);
    #1;
    check({name, "_pending"}, 36'(exp_q.size()), 36'd0);
  endtask

  initial begin
    rst = 1'b1;
    {code_stall, clear_wb, data_stall, clear_alu, shifter_stall, issue_stall} = '0;
    instr_in = '0;
    valid_in = 1'b0;
    irq_in   = 1'b0;
    fiq_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_instr", instr_out, 36'h0_F000_0000);
    check("rst_valid", 36'(valid_out), 36'd0);
    check("rst_irq",   36'(irq_out),   36'd0);
    check("rst_fiq",   36'(fiq_out),   36'd0);
    check("rst_stall", 36'(stall_out), 36'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LDMIA r0!,{r1,r2,r3}
    push(36'h1_E1A0_0000, 0, 0);
    push(36'h2_E590_1000, 0, 0);
    push(36'h2_E590_2004, 0, 0);
    push(36'h2_E590_3008, 0, 0);
    push(36'h2_E280_000C, 0, 0);
    present("ldmia_wb", 36'h0_E8B0_000E, 0, 0, 4);
    drain("ldmia_wb");

    // STMDB sp!,{r4,lr}, cond EQ
    push(36'h1_01A0_000D, 0, 0);
    push(36'h2_0500_4008, 0, 0);
    push(36'h2_0500_E004, 0, 0);
    push(36'h2_0240_D008, 0, 0);
    present("stmdb", 36'h0_092D_4010, 0, 0, 3);
    drain("stmdb");

    // LDMIA r0!,{r0,pc}: base in list, no writeback
    push(36'h1_E1A0_0000, 0, 0);
    push(36'h2_E590_0000, 0, 0);
    push(36'h2_E590_F004, 0, 0);
    present("ldmia_pc", 36'h0_E8B0_8001, 0, 0, 2);
    drain("ldmia_pc");

    // LDMIB r2!,{r3,pc}: writeback before the PC load
    push(36'h1_E1A0_0002, 0, 0);
    push(36'h2_E590_3004, 0, 0);
    push(36'h2_E280_2008, 0, 0);
    push(36'h2_E590_F008, 0, 0);
    present("ldmib_pc", 36'h0_E9B2_8008, 0, 0, 3);
    drain("ldmib_pc");

    // LDMDA r1,{r2,r5} with irq: irq only on the MOV
    push(36'h1_E1A0_0001, 1, 0);
    push(36'h2_E510_2004, 0, 0);
    push(36'h2_E590_5000, 0, 0);
    present("ldmda_irq", 36'h0_E811_0024, 1, 0, 2);
    drain("ldmda_irq");

    // Plain ADD with irq and upper bits set passes unchanged
    push(36'h3_E082_1003, 1, 0);
    present("pass_add", 36'h3_E082_1003, 1, 0, 0);
    drain("pass_add");

    // Empty list: single op with cond forced to NV, fiq carried
    push(36'h0_F8B0_0000, 0, 1);
    present("empty_list", 36'h0_E8B0_0000, 0, 1, 0);
    drain("empty_list");

    // Issue stall holds the 2nd op for 3 cycles; ALU clear on the 3rd aborts
    push(36'h1_E1A0_0000, 0, 0);
    push(36'h2_E590_1000, 0, 0);
    push(36'h2_E590_2004, 0, 0);
    instr_in = 36'h0_E8B0_000E;
    valid_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    issue_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("held_uop",   instr_out, 36'h2_E590_1000);
      check("held_valid", 36'(valid_out), 36'd1);
      @(posedge clk); #1;
    end
    issue_stall = 1'b0;
    @(posedge clk); #1;
    clear_alu = 1'b1;
    valid_in  = 1'b0;
    @(posedge clk); #1;
    clear_alu = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flush_valid", 36'(valid_out), 36'd0);
      check("flush_stall", 36'(stall_out), 36'd0);
      @(posedge clk); #1;
    end
    drain("flush");

    // Reset mid-sequence abandons it
    push(36'h1_E1A0_0000, 0, 0);
    push(36'h2_E590_1000, 0, 0);
    instr_in = 36'h0_E8B0_000E;
    valid_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_instr", instr_out, 36'h0_F000_0000);
    check("midrst_valid", 36'(valid_out), 36'd0);
    drain("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
